regfile_write_arbiter: RTL and testbench
========================================

REGFILE_WRITE_ARBITER -- requirements
Module: regfile_write_arbiter

Interface
REQ-001 SHALL have parameter CNT_W, default 16, width of write counter wr_count.
REQ-002 SHALL have port clk  in  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have port hold  in  1  pipeline stall; blocks all grants while high.
REQ-005 SHALL have ports alu_valid in 1 / alu_rd in 5 / alu_data in 32  ALU writeback request.
REQ-006 SHALL have port alu_ready  out  1  ALU request accepted this cycle.
REQ-007 SHALL have ports lsu_valid in 1 / lsu_rd in 5 / lsu_data in 32  load-unit writeback request.
REQ-008 SHALL have port lsu_ready  out  1  load request accepted this cycle.
REQ-009 SHALL have ports rs1 in 5 / rs2 in 5  source addresses currently presented to register file read ports.
REQ-010 SHALL have port hazard  out  1  read of a register whose write is still in the output stage.
REQ-011 SHALL have ports rf_we out 1 / rf_waddr out 5 / rf_wdata out 32  register file write port (WE3/A3/WD3).
REQ-012 SHALL have port wr_count  out  CNT_W  number of rf_we pulses issued since reset.

Function
REQ-013 Handshake: a request transfers on a rising edge where valid && ready; requester holds rd/data stable while valid && !ready.
REQ-014 Ready signals SHALL be combinational from current valids, hold and arbitration pointer; at most one ready high per cycle.
REQ-015 hold=1: alu_ready=lsu_ready=0, no transfer, output stage loads rf_we=0 on next edge.
REQ-016 Only one valid (hold=0): that requester SHALL receive ready in the same cycle.
REQ-017 Both valid (hold=0): round-robin; grant goes to requester not granted by the most recent two-way contention; pointer updates only on a contended grant; reset pointer favours ALU.
REQ-018 Latency: accepted rd/data SHALL appear on rf_waddr/rf_wdata with rf_we=1 exactly one cycle after the accepting edge, for exactly one cycle unless another transfer follows.
REQ-019 Back-to-back transfers SHALL produce rf_we high on consecutive cycles, no bubble; sustained throughput one write per cycle.
REQ-020 No transfer in a cycle: next cycle rf_we=0; rf_waddr/rf_wdata retain previous values.
REQ-021 rd=0 request SHALL be accepted normally (ready asserted, counts for round-robin) but produce rf_we=0; rf_waddr=0, rf_wdata=data still loaded.
REQ-022 hazard = rf_we && ((rs1!=0 && rs1==rf_waddr) || (rs2!=0 && rs2==rf_waddr)); combinational.
REQ-023 wr_count SHALL increment by 1 on each edge where rf_we is 1; wraps from all-ones to 0.
REQ-024 FSM states: IDLE (output stage empty, rf_we=0) and WRITE (rf_we=1); IDLE->WRITE on transfer with rd!=0; WRITE->WRITE on further such transfer; WRITE->IDLE on no transfer, hold, or rd=0 transfer.
REQ-025 Simultaneous hold rise and both valid: hold wins, no grant, pointer unchanged.
REQ-026 Requester dropping valid without ready: no transfer, no side effect, pointer unchanged.

Reset
REQ-027 rst_n low SHALL immediately force rf_we=0, rf_waddr=0, rf_wdata=0, wr_count=0, state IDLE, pointer favours ALU, independent of clk.
REQ-028 Reset asserted mid-write SHALL cancel the pending write; no rf_we pulse after rst_n release until a new transfer.
REQ-029 During reset alu_ready=lsu_ready=0 and hazard=0.

Verification
REQ-030 ALU only: alu_valid=1, rd=5, data=0x0000000D for one cycle -> alu_ready=1 same cycle; next cycle rf_we=1, rf_waddr=5, rf_wdata=0xD; following cycle rf_we=0; wr_count=1.
REQ-031 Contention: both valid for 4 cycles, distinct rds -> grants alternate ALU, LSU, ALU, LSU; rf_we high 4 consecutive cycles; wr_count=4.
REQ-032 x0 write: lsu_valid=1, rd=0, data=0xFFFFFFFF -> lsu_ready=1; next cycle rf_we=0; wr_count unchanged; next contention granted to ALU.
REQ-033 Hazard: after ALU write rd=10, rs1=10, rs2=3 -> hazard=1 during rf_we cycle only; rs1=0 with rf_waddr=0 -> hazard=0.
REQ-034 Hold: both valid, hold=1 for 3 cycles -> both ready 0, rf_we=0, pointer unchanged; hold release -> ALU granted first.
REQ-035 Reset mid-op: transfer accepted, rst_n pulsed low before next edge -> rf_we=0 immediately, wr_count=0, no write after release.

Source files
------------

// File: rtl/regfile_write_arbiter.sv
// Register file write arbiter: round-robin between ALU and load-unit writeback
// requests, with a single registered output stage that drives the write port.
// The output stage also tracks pending-write hazards and counts issued writes.
module regfile_write_arbiter #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             hold,
    input  logic             alu_valid,
    input  logic [4:0]       alu_rd,
    input  logic [31:0]      alu_data,
    output logic             alu_ready,
    input  logic             lsu_valid,
    input  logic [4:0]       lsu_rd,
    input  logic [31:0]      lsu_data,
    output logic             lsu_ready,
    input  logic [4:0]       rs1,
    input  logic [4:0]       rs2,
    output logic             hazard,
    output logic             rf_we,
    output logic [4:0]       rf_waddr,
    output logic [31:0]      rf_wdata,
    output logic [CNT_W-1:0] wr_count
);

    typedef enum logic {StIdle, StWrite} state_e;

    state_e            state_q, state_d;
    logic              prio_lsu_q, prio_lsu_d;  // 1: LSU wins the next contention
    logic [4:0]        waddr_q, waddr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [CNT_W-1:0]  count_q, count_d;

    logic              contended;
    logic              xfer;
    logic [4:0]        xfer_rd;
    logic [31:0]       xfer_data;

    // Grant: hold and reset block everything; contention resolved by pointer.
    always_comb begin
        contended = alu_valid && lsu_valid;
        alu_ready = rst_n && !hold && alu_valid && !(lsu_valid && prio_lsu_q);
        lsu_ready = rst_n && !hold && lsu_valid && !(alu_valid && !prio_lsu_q);
    end

    // Next-state: select accepted request, advance pointer, FSM and counter.
    always_comb begin
        xfer       = 1'b0;
        xfer_rd    = 5'd0;
        xfer_data  = 32'd0;
        prio_lsu_d = prio_lsu_q;
        waddr_d    = waddr_q;
        wdata_d    = wdata_q;
        state_d    = state_q;
        count_d    = count_q;

        if (alu_ready) begin
            xfer      = 1'b1;
            xfer_rd   = alu_rd;
            xfer_data = alu_data;
        end else if (lsu_ready) begin
            xfer      = 1'b1;
            xfer_rd   = lsu_rd;
            xfer_data = lsu_data;
        end

        // Pointer only moves when both competed; favour the loser next time.
        if (contended && xfer) begin
            prio_lsu_d = alu_ready;
        end

        // rd=0 still loads the output stage, it just never raises rf_we.
        if (xfer) begin
            waddr_d = xfer_rd;
            wdata_d = xfer_data;
        end

        unique case (state_q)
            StIdle:  if (xfer && (xfer_rd != 5'd0)) state_d = StWrite;
            StWrite: if (!(xfer && (xfer_rd != 5'd0))) state_d = StIdle;
            default: state_d = StIdle;
        endcase

        if (state_q == StWrite) begin
            count_d = count_q + 1'b1;
        end
    end

    // State register with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            prio_lsu_q <= 1'b0;
            waddr_q    <= 5'd0;
            wdata_q    <= 32'd0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            prio_lsu_q <= prio_lsu_d;
            waddr_q    <= waddr_d;
            wdata_q    <= wdata_d;
            count_q    <= count_d;
        end
    end

    // Outputs: write port straight from the output stage, hazard on address match.
    always_comb begin
        rf_we    = (state_q == StWrite);
        rf_waddr = waddr_q;
        rf_wdata = wdata_q;
        wr_count = count_q;
        hazard   = rf_we && (((rs1 != 5'd0) && (rs1 == waddr_q)) ||
                             ((rs2 != 5'd0) && (rs2 == waddr_q)));
    end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter. Inputs change 1 ns after the rising
// edge; combinational outputs are sampled 1 ns later, registered ones after the edge.
module tb_regfile_write_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        hold;
    logic        alu_valid, lsu_valid;
    logic [4:0]  alu_rd, lsu_rd;
    logic [31:0] alu_data, lsu_data;
    logic        alu_ready, lsu_ready;
    logic [4:0]  rs1, rs2;
    logic        hazard;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [15:0] wr_count;

    int checks = 0;
    int errors = 0;

    regfile_write_arbiter #(.CNT_W(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .hold      (hold),
        .alu_valid (alu_valid),
        .alu_rd    (alu_rd),
        .alu_data  (alu_data),
        .alu_ready (alu_ready),
        .lsu_valid (lsu_valid),
        .lsu_rd    (lsu_rd),
        .lsu_data  (lsu_data),
        .lsu_ready (lsu_ready),
        .rs1       (rs1),
        .rs2       (rs2),
        .hazard    (hazard),
        .rf_we     (rf_we),
        .rf_waddr  (rf_waddr),
        .rf_wdata  (rf_wdata),
        .wr_count  (wr_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; hold = 1'b0;
        alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'h1;
        lsu_valid = 1'b1; lsu_rd = 5'd4; lsu_data = 32'h2;
        rs1 = 5'd0; rs2 = 5'd0;
        #12;
        checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL reset_we got %b want 0", rf_we); end
        checks++; if (rf_waddr !== 5'd0) begin errors++; $display("FAIL reset_waddr got %0d want 0", rf_waddr); end
        checks++; if (rf_wdata !== 32'd0) begin errors++; $display("FAIL reset_wdata got %h want 0", rf_wdata); end
        checks++; if (wr_count !== 16'd0) begin errors++; $display("FAIL reset_count got %0d want 0", wr_count); end
        checks++; if ({alu_ready, lsu_ready} !== 2'b00) begin errors++; $display("FAIL reset_ready got %b want 00", {alu_ready, lsu_ready}); end
        checks++; if (hazard !== 1'b0) begin errors++; $display("FAIL reset_hazard got %b want 0", hazard); end
        alu_valid = 1'b0; lsu_valid = 1'b0;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_alu_only();
        alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'h0000_000D;
        #1;
        checks++; if ({alu_ready, lsu_ready} !== 2'b10) begin errors++; $display("FAIL alu_only_ready got %b want 10", {alu_ready, lsu_ready}); end
        tick();
        alu_valid = 1'b0;
        checks++; if (rf_we !== 1'b1) begin errors++; $display("FAIL alu_only_we got %b want 1", rf_we); end
        checks++; if (rf_waddr !== 5'd5) begin errors++; $display("FAIL alu_only_waddr got %0d want 5", rf_waddr); end
        checks++; if (rf_wdata !== 32'hD) begin errors++; $display("FAIL alu_only_wdata got %h want 0000000d", rf_wdata); end
        tick();
        checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL alu_only_we_drop got %b want 0", rf_we); end
        checks++; if (rf_waddr !== 5'd5) begin errors++; $display("FAIL alu_only_retain got %0d want 5", rf_waddr); end
        checks++; if (wr_count !== 16'd1) begin errors++; $display("FAIL alu_only_count got %0d want 1", wr_count); end
    endtask

    task automatic test_contention();
        logic [3:0]  exp_alu = 4'b0101;  // bit i: ALU wins cycle i
        logic [4:0]  exp_rd;
        logic [31:0] exp_data;
        alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 32'hA000_0001;
        lsu_valid = 1'b1; lsu_rd = 5'd2; lsu_data = 32'hB000_0002;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++;
            if ({alu_ready, lsu_ready} !== {exp_alu[i], ~exp_alu[i]}) begin
                errors++;
                $display("FAIL contend_grant%0d got %b want %b", i, {alu_ready, lsu_ready},
                         {exp_alu[i], ~exp_alu[i]});
            end
            exp_rd   = 5'(i + 1);
            exp_data = (exp_alu[i] ? 32'hA000_0000 : 32'hB000_0000) + 32'(i + 1);
            tick();
            if (exp_alu[i]) begin
                alu_rd = 5'd3; alu_data = 32'hA000_0003;
            end else begin
                lsu_rd = 5'd4; lsu_data = 32'hB000_0004;
            end
            if (i == 3) begin
                alu_valid = 1'b0; lsu_valid = 1'b0;
            end
            checks++;
            if (rf_we !== 1'b1 || rf_waddr !== exp_rd || rf_wdata !== exp_data) begin
                errors++;
                $display("FAIL contend_write%0d got we=%b a=%0d d=%h want we=1 a=%0d d=%h",
                         i, rf_we, rf_waddr, rf_wdata, exp_rd, exp_data);
            end
        end
        tick();
        checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL contend_we_end got %b want 0", rf_we); end
        checks++; if (wr_count !== 16'd5) begin errors++; $display("FAIL contend_count got %0d want 5", wr_count); end
    endtask

    task automatic test_x0();
        lsu_valid = 1'b1; lsu_rd = 5'd0; lsu_data = 32'hFFFF_FFFF;
        #1;
        checks++; if (lsu_ready !== 1'b1) begin errors++; $display("FAIL x0_ready got %b want 1", lsu_ready); end
        tick();
        lsu_valid = 1'b0;
        checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL x0_we got %b want 0", rf_we); end
        checks++; if (rf_waddr !== 5'd0 || rf_wdata !== 32'hFFFF_FFFF) begin
            errors++; $display("FAIL x0_stage got a=%0d d=%h want a=0 d=ffffffff", rf_waddr, rf_wdata);
        end
        tick();
        checks++; if (wr_count !== 16'd5) begin errors++; $display("FAIL x0_count got %0d want 5", wr_count); end
        // Contention probe only; valids drop before the edge so nothing transfers.
        alu_valid = 1'b1; alu_rd = 5'd6; lsu_valid = 1'b1; lsu_rd = 5'd7;
        #1;
        checks++; if ({alu_ready, lsu_ready} !== 2'b10) begin errors++; $display("FAIL x0_next_grant got %b want 10", {alu_ready, lsu_ready}); end
        alu_valid = 1'b0; lsu_valid = 1'b0;
    endtask

    task automatic test_hazard();
        tick();
        alu_valid = 1'b1; alu_rd = 5'd10; alu_data = 32'h0000_00AA;
        rs1 = 5'd10; rs2 = 5'd3;
        #1;
        checks++; if (hazard !== 1'b0) begin errors++; $display("FAIL hazard_before got %b want 0", hazard); end
        tick();
        alu_valid = 1'b0;
        checks++; if (hazard !== 1'b1) begin errors++; $display("FAIL hazard_rs1 got %b want 1", hazard); end
        rs1 = 5'd0; rs2 = 5'd10;
        #1;
        checks++; if (hazard !== 1'b1) begin errors++; $display("FAIL hazard_rs2 got %b want 1", hazard); end
        rs1 = 5'd10; rs2 = 5'd3;
        tick();
        checks++; if (hazard !== 1'b0) begin errors++; $display("FAIL hazard_after got %b want 0", hazard); end
        lsu_valid = 1'b1; lsu_rd = 5'd0; lsu_data = 32'h1234_5678;
        tick();
        lsu_valid = 1'b0; rs1 = 5'd0; rs2 = 5'd0;
        #1;
        checks++; if (hazard !== 1'b0 || rf_waddr !== 5'd0) begin
            errors++; $display("FAIL hazard_x0 got hz=%b a=%0d want hz=0 a=0", hazard, rf_waddr);
        end
        checks++; if (wr_count !== 16'd6) begin errors++; $display("FAIL hazard_count got %0d want 6", wr_count); end
    endtask

    task automatic test_hold();
        hold = 1'b1;
        alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 32'h7;
        lsu_valid = 1'b1; lsu_rd = 5'd8; lsu_data = 32'h8;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if ({alu_ready, lsu_ready} !== 2'b00) begin errors++; $display("FAIL hold_ready%0d got %b want 00", i, {alu_ready, lsu_ready}); end
            tick();
            checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL hold_we%0d got %b want 0", i, rf_we); end
        end
        hold = 1'b0;
        #1;
        checks++; if ({alu_ready, lsu_ready} !== 2'b10) begin errors++; $display("FAIL hold_release got %b want 10", {alu_ready, lsu_ready}); end
        tick();
        alu_rd = 5'd11; alu_data = 32'hB;
        checks++; if (rf_we !== 1'b1 || rf_waddr !== 5'd7) begin
            errors++; $display("FAIL hold_write got we=%b a=%0d want we=1 a=7", rf_we, rf_waddr);
        end
        #1;
        checks++; if ({alu_ready, lsu_ready} !== 2'b01) begin errors++; $display("FAIL hold_rr got %b want 01", {alu_ready, lsu_ready}); end
        // Both withdraw without a transfer; pointer must stay on LSU.
        alu_valid = 1'b0; lsu_valid = 1'b0;
        tick();
        checks++; if (rf_we !== 1'b0 || wr_count !== 16'd7) begin
            errors++; $display("FAIL hold_withdraw got we=%b cnt=%0d want we=0 cnt=7", rf_we, wr_count);
        end
        alu_valid = 1'b1; lsu_valid = 1'b1;
        #1;
        checks++; if ({alu_ready, lsu_ready} !== 2'b01) begin errors++; $display("FAIL hold_ptr_kept got %b want 01", {alu_ready, lsu_ready}); end
        alu_valid = 1'b0; lsu_valid = 1'b0;
    endtask

    task automatic test_reset_midop();
        tick();
        alu_valid = 1'b1; alu_rd = 5'd9; alu_data = 32'h9999_0000;
        tick();
        alu_valid = 1'b0;
        checks++; if (rf_we !== 1'b1) begin errors++; $display("FAIL midop_we_pre got %b want 1", rf_we); end
        #1;
        rst_n = 1'b0;
        alu_valid = 1'b1; lsu_valid = 1'b1;
        #1;
        checks++; if (rf_we !== 1'b0 || rf_waddr !== 5'd0 || rf_wdata !== 32'd0) begin
            errors++; $display("FAIL midop_clear got we=%b a=%0d d=%h want 0/0/0", rf_we, rf_waddr, rf_wdata);
        end
        checks++; if (wr_count !== 16'd0) begin errors++; $display("FAIL midop_count got %0d want 0", wr_count); end
        checks++; if ({alu_ready, lsu_ready} !== 2'b00) begin errors++; $display("FAIL midop_ready got %b want 00", {alu_ready, lsu_ready}); end
        alu_valid = 1'b0; lsu_valid = 1'b0;
        rst_n = 1'b1;
        tick();
        checks++; if (rf_we !== 1'b0 || wr_count !== 16'd0) begin
            errors++; $display("FAIL midop_release got we=%b cnt=%0d want we=0 cnt=0", rf_we, wr_count);
        end
        tick();
        checks++; if (rf_we !== 1'b0 || wr_count !== 16'd0) begin
            errors++; $display("FAIL midop_quiet got we=%b cnt=%0d want we=0 cnt=0", rf_we, wr_count);
        end
        // Reset returns the pointer to ALU.
        alu_valid = 1'b1; lsu_valid = 1'b1;
        #1;
        checks++; if ({alu_ready, lsu_ready} !== 2'b10) begin errors++; $display("FAIL midop_ptr got %b want 10", {alu_ready, lsu_ready}); end
        alu_valid = 1'b0; lsu_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_alu_only();
        test_contention();
        test_x0();
        test_hazard();
        test_hold();
        test_reset_midop();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout got running want finished");
        $fatal(1, "timeout");
    end

endmodule
